// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, instruction-format and encoder-state types.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_S, FMT_SB} fmt_e;
    typedef enum logic [1:0] {IDLE, RUN, DONE} enc_state_e;

    // Unknown opcodes fall back to the I layout.
    function automatic fmt_e opc_fmt(input logic [6:0] op);
        case (op)
            OPC_OP:                       return FMT_R;
            OPC_STORE:                    return FMT_S;
            OPC_BRANCH:                   return FMT_SB;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: return FMT_I;
            default:                      return FMT_I;
        endcase
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational RV32I field packer (R/I/S/SB). With IMM_RANGE_CHECK_EN defined
// it also flags immediates that do not fit the selected format.
module instr_field_pack
    import riscv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word
`ifdef IMM_RANGE_CHECK_EN
    ,
    output logic        range_err
`endif
);

    fmt_e fmt;
    assign fmt = opc_fmt(opcode);

    always_comb begin
        case (fmt)
            FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_SB:  word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            default: word = {imm[11:0], rs1, funct3, rd, opcode};
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = $signed(imm);

    // Branch offsets are halfword aligned, so bit 0 set is also an error.
    always_comb begin
        case (fmt)
            FMT_R:   range_err = 1'b0;
            FMT_SB:  range_err = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
            default: range_err = (simm < -32'sd2048) || (simm > 32'sd2047);
        endcase
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:13];
`endif

endmodule

// File: rtl/instr_encoder.sv
// Burst instruction encoder: packs field bundles and streams them to imem.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              imm_err
);

    enc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [31:0]       packed_word;
    logic              start_acc, accept, drain, last_drain;

`ifdef IMM_RANGE_CHECK_EN
    logic range_err;
    logic imm_err_q, imm_err_d;
`endif

    instr_field_pack u_pack (
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .word      (packed_word)
`ifdef IMM_RANGE_CHECK_EN
        ,
        .range_err (range_err)
`endif
    );

    assign start_acc  = (state_q == IDLE) & start;
    assign drain      = we_q & mem_ready;
    // A slot is free when the output register is empty or draining this cycle.
    assign in_ready   = busy & (~we_q | mem_ready) & (acc_cnt_q < num_q);
    assign accept     = in_valid & in_ready;
    assign last_drain = busy & drain & (wr_cnt_q == num_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_words == '0) ? DONE : RUN;
            RUN:     if (last_drain) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        num_d       = num_q;
        acc_cnt_d   = acc_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        next_addr_d = next_addr_q;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q & ~mem_ready;
        if (start_acc) begin
            num_d       = num_words;
            acc_cnt_d   = '0;
            wr_cnt_d    = '0;
            next_addr_d = base_addr & ~ADDR_W'(3);
        end
        if (accept) begin
            acc_cnt_d   = acc_cnt_q + CNT_W'(1);
            next_addr_d = next_addr_q + ADDR_W'(4);
            mem_addr_d  = next_addr_q;
            wdata_d     = packed_word;
            we_d        = 1'b1;
        end
        if (drain) wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_q       <= '0;
            acc_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            next_addr_q <= '0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
        end else begin
            num_q       <= num_d;
            acc_cnt_q   <= acc_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            next_addr_q <= next_addr_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = wdata_q;

`ifdef IMM_RANGE_CHECK_EN
    // Sticky for the whole burst; a new accepted start clears it.
    always_comb begin
        imm_err_d = imm_err_q;
        if (start_acc)            imm_err_d = 1'b0;
        if (accept && range_err)  imm_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) imm_err_q <= 1'b0;
        else       imm_err_q <= imm_err_d;
    end

    assign imm_err = imm_err_q;
`else
    assign imm_err = 1'b0;
`endif

endmodule
